// File: rtl/acc_result_collector.sv
// Result collector: captures core accumulator results into a FIFO tagged with layer id and
// in-frame index, stalls the core when full or idle, and streams results downstream.
module acc_result_collector #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic [7:0]               conf_id_i,
    input  logic [IDX_W-1:0]         frame_len_i,
    input  logic                     acc_valid_i,
    input  logic [31:0]              acc_data_i,
    output logic                     stall_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_data_o,
    output logic [7:0]               out_id_o,
    output logic [IDX_W-1:0]         out_idx_o,
    output logic                     out_last_o,
    output logic                     frame_done_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
    } entry_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [7:0]       id_q, id_d;
    logic             frame_done_q, frame_done_d;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic             full, empty, push, pop, last_push;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign stall_o   = (state_q != RUN) | full;
    assign push      = acc_valid_i & ~stall_o;
    assign last_push = push & (wr_idx_q == len_q - IDX_W'(1));

    // Head fields are gated by valid so unwritten entries never reach the ports.
    assign head         = mem[rd_ptr_q];
    assign out_valid_o  = ~empty;
    assign pop          = out_valid_o & out_ready_i;
    assign out_data_o   = out_valid_o ? head.data : '0;
    assign out_idx_o    = out_valid_o ? head.idx  : '0;
    assign out_last_o   = out_valid_o & (head.idx == len_q - IDX_W'(1));
    assign out_id_o     = id_q;
    assign frame_done_o = frame_done_q;
    assign count_o      = count_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wr_idx_d     = wr_idx_q;
        len_d        = len_q;
        id_d         = id_q;
        frame_done_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!last_push) begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start_i && (frame_len_i != '0)) begin
                    id_d     = conf_id_i;
                    len_d    = frame_len_i;
                    wr_idx_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (last_push) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last_o) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; an entry is only visible once written, as count gates it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= '{data: acc_data_i, idx: wr_idx_q};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_idx_q     <= '0;
            len_q        <= '0;
            id_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_idx_q     <= wr_idx_d;
            len_q        <= len_d;
            id_q         <= id_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_acc_result_collector.sv
// Scoreboard bench for acc_result_collector: a core-side driver queues expected results as the
// core hands them over, and a separate monitor pops and compares every downstream transfer.
module tb_acc_result_collector;
    localparam int DEPTH = 16;
    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start_i = 1'b0;
    logic [7:0]       conf_id_i = '0;
    logic [IDX_W-1:0] frame_len_i = '0;
    logic             acc_valid_i = 1'b0;
    logic [31:0]      acc_data_i = '0;
    logic             stall_o;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [31:0]      out_data_o;
    logic [7:0]       out_id_o;
    logic [IDX_W-1:0] out_idx_o;
    logic             out_last_o;
    logic             frame_done_o;
    logic [$clog2(DEPTH):0] count_o;

    acc_result_collector #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clock(clk), .reset(reset), .start_i(start_i), .conf_id_i(conf_id_i),
        .frame_len_i(frame_len_i), .acc_valid_i(acc_valid_i), .acc_data_i(acc_data_i),
        .stall_o(stall_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_id_o(out_id_o), .out_idx_o(out_idx_o),
        .out_last_o(out_last_o), .frame_done_o(frame_done_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] idx;
        logic [7:0]  id;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0;
    int          failed = 0;
    int          done_seen = 0;
    bit          in_reset = 1'b1;
    bit          ready_rand = 1'b0;
    logic        ready_level = 1'b1;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_data;
    logic [15:0] prev_idx;
    logic        done_due = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fp_of(input int k);
        case (k)
            0:       return 32'h3F80_0000;
            1:       return 32'h4000_0000;
            2:       return 32'h4040_0000;
            3:       return 32'h4080_0000;
            default: return 32'h0;
        endcase
    endfunction

    // Downstream ready: fixed level or random per cycle, changed just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Monitor: compares every transfer against the scoreboard, plus hold stability and done pulse.
    always @(negedge clk) begin
        if (in_reset) begin
            hold_prev = 1'b0;
            done_due  = 1'b0;
        end else begin
            if (hold_prev)
                check("hold_stable", {out_valid_o, out_data_o, out_idx_o}, {1'b1, prev_data, prev_idx});
            check("frame_done", frame_done_o, done_due);
            if (frame_done_o) done_seen++;
            done_due = 1'b0;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL unexpected_output: got data %h idx %0d, expected no output", out_data_o, out_idx_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_word", {out_data_o, out_idx_o, out_id_o, out_last_o}, e);
                    done_due = e.last;
                end
            end
            hold_prev = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            prev_idx  = out_idx_o;
        end
    end

    task automatic start_frame(input logic [7:0] id, input int len);
        start_i     = 1'b1;
        conf_id_i   = id;
        frame_len_i = IDX_W'(len);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Core model: presents word k and holds it while stalled; advances only when handed over.
    task automatic drive_frame(input logic [7:0] id, input int len, input int k0, input int k_end,
                               input int valid_pct, input bit fp);
        int          k = k0;
        int          cyc = 0;
        bit          acc;
        logic [31:0] word;
        word = fp ? fp_of(k) : $urandom;
        while (k < k_end && cyc < 4000) begin
            acc_valid_i = ($urandom_range(1, 100) <= valid_pct);
            acc_data_i  = word;
            acc = acc_valid_i && !stall_o;
            if (acc) exp_q.push_back('{data: word, idx: 16'(k), id: id, last: (k == len - 1)});
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                k++;
                word = fp ? fp_of(k) : $urandom;
            end
        end
        acc_valid_i = 1'b0;
        check("drive_pushes", k, k_end);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (done_seen < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("done_count", done_seen, target);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stall"}, stall_o, 1'b1);
        check({tag, "_outs"}, {out_valid_o, out_data_o, out_id_o, out_idx_o, out_last_o, frame_done_o},
              '0);
        check({tag, "_count"}, count_o, 0);
    endtask

    initial begin
        logic [31:0] w;

        // 1. reset and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset    = 1'b0;
        in_reset = 1'b0;
        acc_valid_i = 1'b1;
        acc_data_i  = $urandom;
        repeat (3) @(posedge clk);
        #1;
        acc_valid_i = 1'b0;
        check("idle_count", count_o, 0);
        check("idle_valid", out_valid_o, 1'b0);
        check("idle_stall", stall_o, 1'b1);
        start_frame(8'h55, 0);
        check("len0_stall", stall_o, 1'b1);
        check("len0_id", out_id_o, 8'h00);

        // 2. basic frame of four fp32 words
        start_frame(8'h2A, 4);
        drive_frame(8'h2A, 4, 0, 4, 100, 1'b1);
        wait_done(1, 200);
        check("t2_idle_stall", stall_o, 1'b1);
        check("t2_idle_valid", out_valid_o, 1'b0);

        // 3. back-pressure fills the FIFO, held valid is not recaptured
        ready_level = 1'b0;
        start_frame(8'h33, 20);
        fork
            drive_frame(8'h33, 20, 0, 20, 100, 1'b0);
        join_none
        repeat (30) @(posedge clk);
        #1;
        check("t3_full_count", count_o, DEPTH);
        check("t3_full_stall", stall_o, 1'b1);
        ready_level = 1'b1;
        wait_done(2, 500);

        // 4. latency with an empty FIFO, then steady push+pop
        start_frame(8'h11, 8);
        check("t4_pre_valid", out_valid_o, 1'b0);
        check("t4_run_stall", stall_o, 1'b0);
        w = $urandom;
        acc_valid_i = 1'b1;
        acc_data_i  = w;
        exp_q.push_back('{data: w, idx: 16'd0, id: 8'h11, last: 1'b0});
        @(posedge clk);
        #1;
        acc_valid_i = 1'b0;
        check("t4_valid_n1", out_valid_o, 1'b1);
        check("t4_count_n1", count_o, 1);
        @(posedge clk);
        #1;
        check("t4_count_n2", count_o, 0);
        for (int i = 1; i < 8; i++) begin
            w = $urandom;
            acc_valid_i = 1'b1;
            acc_data_i  = w;
            exp_q.push_back('{data: w, idx: 16'(i), id: 8'h11, last: (i == 7)});
            @(posedge clk);
            #1;
            check("t4_steady_count", count_o, 1);
        end
        acc_valid_i = 1'b0;
        wait_done(3, 200);

        // 5. random ready and random valid over a longer frame
        ready_rand = 1'b1;
        start_frame(8'h5C, 37);
        drive_frame(8'h5C, 37, 0, 37, 70, 1'b0);
        wait_done(4, 2000);
        ready_rand  = 1'b0;
        ready_level = 1'b0;

        // 6. reset mid-frame with five entries queued, then a one-result frame
        start_frame(8'h77, 10);
        drive_frame(8'h77, 10, 0, 5, 100, 1'b0);
        check("t6_queued", count_o, 5);
        reset    = 1'b1;
        in_reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_values("midreset");
        reset       = 1'b0;
        in_reset    = 1'b0;
        ready_level = 1'b1;
        start_frame(8'h09, 1);
        drive_frame(8'h09, 1, 0, 1, 100, 1'b0);
        wait_done(5, 200);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        check("done_total", done_seen, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
